apb_bus_arbiter: RTL and testbench

- Two-requester arbiter and APB master that shares one APB peripheral bus between the CPU data port (requester 0, driven by the core's load/store sequencing) and a DMA/debug port (requester 1).
- Arbitrates round-robin and decodes the address to one of NUM_SLAVES PSEL lines.
- Runs APB SETUP/ACCESS phases and returns a one-cycle ready pulse, with rdata and err, to the granted requester.
- Sits between the core/DMA and the peripheral slaves (RAM, GPIO, UART, ...).

---
 rtl/apb_bus_arbiter_pkg.sv | 20 ++
 rtl/apb_bus_arbiter_rr_arbiter2.sv | 42 ++++
 rtl/apb_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_bus_arbiter_pkg.sv
// Shared definitions for the APB bus arbiter: FSM states, bus widths and
// the address field used to pick the target slave.
package apb_bus_arbiter_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Slave index lives in addr[DEC_MSB:DEC_LSB]; all other upper bits are ignored.
    localparam int DEC_LSB = 12;
    localparam int DEC_MSB = 15;
    localparam int DEC_W   = DEC_MSB - DEC_LSB + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_bus_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// last time is granted; last_grant only moves when the owner strobes update.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant,
    output logic       any_req
);

    logic last_grant_q;
    logic last_grant_d;

    // Pick the winner for the current request pattern and the next history bit.
    always_comb begin
        grant        = 1'b0;
        any_req      = |req;
        last_grant_d = last_grant_q;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
        if (update) begin
            last_grant_d = grant;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // History register; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Shares one APB bus between the CPU data port (requester 0) and the
// DMA/debug port (requester 1). Round-robin arbitration, address decode to
// one-hot PSEL, SETUP/ACCESS sequencing, wait-state timeout and decode error.
module apb_bus_arbiter
    import apb_bus_arbiter_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req0_valid,
    input  logic                           req0_we,
    input  logic [APB_ADDR_W-1:0]          req0_addr,
    input  logic [APB_DATA_W-1:0]          req0_wdata,
    output logic                           req0_ready,
    output logic [APB_DATA_W-1:0]          req0_rdata,
    output logic                           req0_err,
    input  logic                           req1_valid,
    input  logic                           req1_we,
    input  logic [APB_ADDR_W-1:0]          req1_addr,
    input  logic [APB_DATA_W-1:0]          req1_wdata,
    output logic                           req1_ready,
    output logic [APB_DATA_W-1:0]          req1_rdata,
    output logic                           req1_err,
    output logic [APB_ADDR_W-1:0]          paddr,
    output logic                           pwrite,
    output logic                           penable,
    output logic [NUM_SLAVES-1:0]          psel,
    output logic [APB_DATA_W-1:0]          pwdata,
    input  logic [APB_DATA_W*NUM_SLAVES-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]          pready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [DEC_W:0]   NS_LIMIT  = (DEC_W + 1)'(NUM_SLAVES);

    apb_state_e            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  we_q, we_d;
    logic [APB_ADDR_W-1:0] addr_q, addr_d;
    logic [APB_DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

    logic                  arb_grant_s;
    logic                  arb_any_s;
    logic                  arb_update_s;
    logic [APB_ADDR_W-1:0] cand_addr_s;
    logic                  cand_decerr_s;
    logic [DEC_W-1:0]      idx_s;
    logic                  bus_active_s;
    logic                  sel_pready_s;
    logic [APB_DATA_W-1:0] sel_rdata_s;
    logic                  done_s;
    logic                  err_s;
    logic [APB_DATA_W-1:0] rdata_s;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .update  (arb_update_s),
        .grant   (arb_grant_s),
        .any_req (arb_any_s)
    );

    assign cand_addr_s   = arb_grant_s ? req1_addr : req0_addr;
    assign cand_decerr_s = ({1'b0, cand_addr_s[DEC_MSB:DEC_LSB]} >= NS_LIMIT);
    assign idx_s         = addr_q[DEC_MSB:DEC_LSB];
    assign bus_active_s  = (state_q == SETUP) || (state_q == ACCESS);

    // Select ready/read data of the addressed slave; other slaves are ignored.
    always_comb begin
        sel_pready_s = 1'b0;
        sel_rdata_s  = {APB_DATA_W{1'b0}};
        psel         = {NUM_SLAVES{1'b0}};
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_s == k[DEC_W-1:0]) begin
                sel_pready_s = pready[k];
                sel_rdata_s  = prdata[APB_DATA_W*k +: APB_DATA_W];
                psel[k]      = bus_active_s;
            end else begin
                psel[k]      = 1'b0;
            end
        end
    end

    // Next-state logic: arbitration and latching in IDLE, APB phase sequencing after.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        arb_update_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    arb_update_s = 1'b1;
                    grant_d      = arb_grant_s;
                    we_d         = arb_grant_s ? req1_we    : req0_we;
                    addr_d       = cand_addr_s;
                    wdata_d      = arb_grant_s ? req1_wdata : req0_wdata;
                    wait_cnt_d   = {CNT_W{1'b0}};
                    if (cand_decerr_s) begin
                        state_d = DECERR;
                    end else begin
                        state_d = SETUP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                wait_cnt_d = {CNT_W{1'b0}};
            end
            ACCESS: begin
                if (sel_pready_s || (wait_cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                end else begin
                    state_d    = ACCESS;
                    wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DECERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {APB_ADDR_W{1'b0}};
            wdata_q    <= {APB_DATA_W{1'b0}};
            wait_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign paddr   = addr_q;
    assign pwrite  = we_q;
    assign pwdata  = wdata_q;
    assign penable = (state_q == ACCESS);

    // Completion: slave ready, wait-state timeout, or decode error; only the granted side sees it.
    always_comb begin
        done_s = 1'b0;
        err_s  = 1'b0;
        rdata_s = {APB_DATA_W{1'b0}};
        if (state_q == ACCESS) begin
            done_s  = sel_pready_s || (wait_cnt_q == CNT_LAST);
            err_s   = ~sel_pready_s;
            rdata_s = (sel_pready_s && !we_q) ? sel_rdata_s : {APB_DATA_W{1'b0}};
        end else if (state_q == DECERR) begin
            done_s  = 1'b1;
            err_s   = 1'b1;
            rdata_s = {APB_DATA_W{1'b0}};
        end else begin
            done_s  = 1'b0;
        end
        req0_ready = done_s && !grant_q;
        req0_err   = done_s && !grant_q && err_s;
        req0_rdata = (done_s && !grant_q) ? rdata_s : {APB_DATA_W{1'b0}};
        req1_ready = done_s && grant_q;
        req1_err   = done_s && grant_q && err_s;
        req1_rdata = (done_s && grant_q) ? rdata_s : {APB_DATA_W{1'b0}};
    end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed bench for apb_bus_arbiter (NUM_SLAVES=4, TIMEOUT=16).
module tb_apb_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_we, req0_ready, req0_err;
    logic [31:0]  req0_addr, req0_wdata, req0_rdata;
    logic         req1_valid, req1_we, req1_ready, req1_err;
    logic [31:0]  req1_addr, req1_wdata, req1_rdata;
    logic [31:0]  paddr, pwdata;
    logic         pwrite, penable;
    logic [3:0]   psel;
    logic [127:0] prdata;
    logic [3:0]   pready;

    int checks   = 0;
    int failures = 0;

    apb_bus_arbiter #(.NUM_SLAVES(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .paddr(paddr), .pwrite(pwrite), .penable(penable), .psel(psel),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are looked at 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
        pready = 4'b0000;
        prdata = 128'h0;
        prdata[31:0]   = 32'h0000_0A0A;
        prdata[63:32]  = 32'hDEAD_BEEF;
        prdata[95:64]  = 32'h2222_2222;
        prdata[127:96] = 32'h3333_CAFE;
        tick(); tick();
        chk("rst_psel",    32'(psel),       32'h0);
        chk("rst_penable", 32'(penable),    32'h0);
        chk("rst_ready0",  32'(req0_ready), 32'h0);
        chk("rst_ready1",  32'(req1_ready), 32'h0);
        chk("rst_paddr",   paddr,           32'h0);
        rst = 1'b0;
        tick();

        // Single read from slave 1
        pready = 4'b0010;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0000_1004;
        #1;
        chk("rd_n_psel", 32'(psel), 32'h0);
        tick();
        chk("rd_n1_psel",    32'(psel),       32'h2);
        chk("rd_n1_penable", 32'(penable),    32'h0);
        chk("rd_n1_paddr",   paddr,           32'h0000_1004);
        chk("rd_n1_ready0",  32'(req0_ready), 32'h0);
        tick();
        chk("rd_n2_psel",    32'(psel),       32'h2);
        chk("rd_n2_penable", 32'(penable),    32'h1);
        chk("rd_n2_ready0",  32'(req0_ready), 32'h1);
        chk("rd_n2_rdata0",  req0_rdata,      32'hDEAD_BEEF);
        chk("rd_n2_err0",    32'(req0_err),   32'h0);
        chk("rd_n2_ready1",  32'(req1_ready), 32'h0);
        req0_valid = 1'b0;
        tick();
        chk("rd_n3_psel",   32'(psel),       32'h0);
        chk("rd_n3_ready0", 32'(req0_ready), 32'h0);

        // Write to slave 2 with three wait states
        pready = 4'b0000;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h0000_2000; req1_wdata = 32'h55AA_55AA;
        tick();
        chk("wr_n1_psel",   32'(psel),   32'h4);
        chk("wr_n1_pwrite", 32'(pwrite), 32'h1);
        chk("wr_n1_pwdata", pwdata,      32'h55AA_55AA);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_wait_penable", 32'(penable),    32'h1);
            chk("wr_wait_paddr",   paddr,           32'h0000_2000);
            chk("wr_wait_pwdata",  pwdata,          32'h55AA_55AA);
            chk("wr_wait_ready1",  32'(req1_ready), 32'h0);
        end
        tick();
        pready = 4'b0100;
        #1;
        chk("wr_n5_ready1", 32'(req1_ready), 32'h1);
        chk("wr_n5_rdata1", req1_rdata,      32'h0);
        chk("wr_n5_err1",   32'(req1_err),   32'h0);
        chk("wr_n5_ready0", 32'(req0_ready), 32'h0);
        req1_valid = 1'b0; req1_we = 1'b0;
        tick();

        // Contention: both requesters hold valid over four transfers
        pready = 4'b0011;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0000_0010;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h0000_1020;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("cont_setup_psel", 32'(psel), (t % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("cont_ready0", 32'(req0_ready), (t % 2 == 0) ? 32'h1 : 32'h0);
            chk("cont_ready1", 32'(req1_ready), (t % 2 == 0) ? 32'h0 : 32'h1);
            chk("cont_rdata",  (t % 2 == 0) ? req0_rdata : req1_rdata,
                               (t % 2 == 0) ? 32'h0000_0A0A : 32'hDEAD_BEEF);
            if (t == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
        end
        chk("cont_idle_psel", 32'(psel), 32'h0);

        // Decode error: slave index 15 does not exist
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0000_F000;
        tick();
        chk("dec_psel",    32'(psel),       32'h0);
        chk("dec_penable", 32'(penable),    32'h0);
        chk("dec_ready0",  32'(req0_ready), 32'h1);
        chk("dec_err0",    32'(req0_err),   32'h1);
        chk("dec_rdata0",  req0_rdata,      32'h0);
        req0_valid = 1'b0;
        tick();
        chk("dec_after_ready0", 32'(req0_ready), 32'h0);

        // Timeout on slave 0: completes with err in the 16th ACCESS cycle
        pready = 4'b0000;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0000_0000;
        tick();
        chk("to_setup_psel", 32'(psel), 32'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_wait_ready0",  32'(req0_ready), 32'h0);
            chk("to_wait_penable", 32'(penable),    32'h1);
        end
        tick();
        chk("to_ready0", 32'(req0_ready), 32'h1);
        chk("to_err0",   32'(req0_err),   32'h1);
        chk("to_rdata0", req0_rdata,      32'h0);
        req0_valid = 1'b0;
        tick();
        chk("to_idle_psel", 32'(psel), 32'h0);

        // Next request proceeds normally; upper address bits are ignored
        pready = 4'b1000;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'hFFFF_3000;
        tick();
        chk("post_to_psel", 32'(psel), 32'h8);
        tick();
        chk("post_to_ready1", 32'(req1_ready), 32'h1);
        chk("post_to_rdata1", req1_rdata,      32'h3333_CAFE);
        chk("post_to_err1",   32'(req1_err),   32'h0);
        req1_valid = 1'b0;
        tick();

        // Reset in the middle of ACCESS
        pready = 4'b0000;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h0000_1000; req0_wdata = 32'h1234_5678;
        tick();
        tick();
        chk("rstm_penable_before", 32'(penable), 32'h1);
        pready = 4'b0010;
        rst = 1'b1;
        #1;
        chk("rstm_psel",    32'(psel),       32'h0);
        chk("rstm_penable", 32'(penable),    32'h0);
        chk("rstm_ready0",  32'(req0_ready), 32'h0);
        req0_valid = 1'b0; req0_we = 1'b0;
        tick();
        rst = 1'b0;
        pready = 4'b0011;
        req0_valid = 1'b1; req0_addr = 32'h0000_0000;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h0000_1000;
        tick();
        chk("rstm_grant_psel", 32'(psel), 32'h1);
        tick();
        chk("rstm_ready0", 32'(req0_ready), 32'h1);
        chk("rstm_ready1", 32'(req1_ready), 32'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
